// File: rtl/axi_slave_w_ctrl_if.sv
// Bus bundle for the W-channel controller: W beats, AW FIFO head/pop,
// memory write port and B FIFO push.
interface axi_slave_w_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  wvalid_i;
  logic [ID_WIDTH-1:0]   wid_i;
  logic [BYTES-1:0]      wstrb_i;
  logic                  wlast_i;
  logic                  wready_o;

  logic                  empty_i;
  logic                  rden_o;
  logic [ADDR_WIDTH-1:0] awaddr_i;
  logic [ID_WIDTH-1:0]   awid_i;
  logic [LEN_WIDTH-1:0]  awlen_i;
  logic [2:0]            awsize_i;
  logic [1:0]            awburst_i;

  logic                  mem_wren_o;
  logic [ADDR_WIDTH-1:0] mem_waddr_o;
  logic [BYTES-1:0]      mem_wstrb_o;

  logic                  full_i;
  logic                  wren_o;
  logic [ID_WIDTH-1:0]   bid_o;
  logic [1:0]            bresp_o;

  modport slave (
    input  wvalid_i, wid_i, wstrb_i, wlast_i,
    output wready_o,
    input  empty_i, awaddr_i, awid_i, awlen_i, awsize_i, awburst_i,
    output rden_o,
    output mem_wren_o, mem_waddr_o, mem_wstrb_o,
    input  full_i,
    output wren_o, bid_o, bresp_o
  );

  modport master (
    output wvalid_i, wid_i, wstrb_i, wlast_i,
    input  wready_o,
    output empty_i, awaddr_i, awid_i, awlen_i, awsize_i, awburst_i,
    input  rden_o,
    input  mem_wren_o, mem_waddr_o, mem_wstrb_o,
    output full_i,
    input  wren_o, bid_o, bresp_o
  );
endinterface

// File: rtl/axi_slave_w_ctrl.sv
// AXI write-data channel controller: pops one AW descriptor, accepts its W
// beats with per-beat memory address/strobe, then pushes ID+BRESP to the B FIFO.
//
// state   | meaning
// S_IDLE  | waiting for an AW descriptor; pops and latches it
// S_BURST | accepting W beats, one per cycle when wvalid_i
// S_RESP  | pushing the B response, stalled while the B FIFO is full
module axi_slave_w_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  axi_slave_w_ctrl_if.slave bus
);
  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(BYTES));

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_RESP} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_cfg_err;
  logic                  w_beat_err;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_incr_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  function automatic logic f_wrap_len_ok(input logic [LEN_WIDTH-1:0] len);
    return (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
           (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
  endfunction

  assign w_accept    = (r_state == S_BURST) && bus.wvalid_i;
  assign w_last_beat = (r_cnt == r_len);

  // Configuration errors are known at pop time, so they seed the sticky flag.
  assign w_cfg_err = (bus.awsize_i > SIZE_MAX) || (bus.awburst_i == 2'b11) ||
                     ((bus.awburst_i == 2'b10) && !f_wrap_len_ok(bus.awlen_i));
  assign w_beat_err = (bus.wlast_i != w_last_beat) || (bus.wid_i != r_id);

  assign w_step      = ADDR_WIDTH'(1) << r_size;
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
  assign w_incr_addr = (r_addr & ~(w_step - ADDR_WIDTH'(1))) + w_step;

  always_comb begin
    w_next_addr = w_incr_addr;
    unique case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   if (f_wrap_len_ok(r_len))
                 w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default: w_next_addr = w_incr_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!bus.empty_i) begin
            r_addr  <= bus.awaddr_i;
            r_id    <= bus.awid_i;
            r_len   <= bus.awlen_i;
            r_size  <= bus.awsize_i;
            r_burst <= bus.awburst_i;
            r_cnt   <= '0;
            r_err   <= w_cfg_err;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_accept) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + LEN_WIDTH'(1);
            r_err  <= r_err | w_beat_err;
            if (w_last_beat) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!bus.full_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rden_o      = (r_state == S_IDLE) && !bus.empty_i;
  assign bus.wready_o    = (r_state == S_BURST);
  assign bus.mem_wren_o  = w_accept;
  assign bus.mem_waddr_o = r_addr;
  assign bus.mem_wstrb_o = w_accept ? bus.wstrb_i : '0;
  assign bus.wren_o      = (r_state == S_RESP) && !bus.full_i;
  assign bus.bid_o       = r_id;
  assign bus.bresp_o     = r_err ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_slave_w_ctrl.sv
// Randomized bench for axi_slave_w_ctrl: each burst's address sequence and
// BRESP come from an arithmetic reference model of the burst rules.
module tb_axi_slave_w_ctrl;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 128;
  localparam int ID_WIDTH   = 4;
  localparam int LEN_WIDTH  = 8;
  localparam int BYTES      = DATA_WIDTH / 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  axi_slave_w_ctrl_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  axi_slave_w_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit wrap_len_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  // Address of beat i: FIXED repeats the start; WRAP walks the start offset
  // round a W-byte window; anything else steps from the aligned start.
  function automatic logic [15:0] model_addr(input int addr, input int len, input int size,
                                             input int burst, input int i);
    int step;
    int w;
    int lower;
    step = 1 << size;
    w    = (len + 1) * step;
    if (burst == 0 || i == 0) return 16'(addr);
    if (burst == 2 && wrap_len_ok(len)) begin
      lower = addr - (addr % w);
      return 16'(lower + ((addr - lower) + i * step) % w);
    end
    return 16'((addr - (addr % step)) + i * step);
  endfunction

  task automatic idle_inputs();
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    bus.wid_i    = '0;
    bus.wstrb_i  = '0;
    bus.empty_i  = 1'b1;
    bus.full_i   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wready"}, 32'(bus.wready_o), 0);
    check_eq({tag, "_rden"},   32'(bus.rden_o), 0);
    check_eq({tag, "_memwr"},  32'(bus.mem_wren_o), 0);
    check_eq({tag, "_waddr"},  32'(bus.mem_waddr_o), 0);
    check_eq({tag, "_wstrb"},  32'(bus.mem_wstrb_o), 0);
    check_eq({tag, "_wren"},   32'(bus.wren_o), 0);
    check_eq({tag, "_bid"},    32'(bus.bid_o), 0);
    check_eq({tag, "_bresp"},  32'(bus.bresp_o), 0);
  endtask

  // gap_mode: 0 no gaps, 1 random gaps, 2 one gap before every odd beat.
  task automatic run_burst(input int addr, input int id, input int len, input int size,
                           input int burst, input int wlast_beat, input bit bad_wid,
                           input int gap_mode, input int n_full);
    bit              exp_err;
    int              ng;
    logic [BYTES-1:0] strb;
    exp_err = (size > $clog2(BYTES)) || (burst == 3) ||
              (burst == 2 && !wrap_len_ok(len)) || (wlast_beat != len) || bad_wid;

    @(negedge clk);
    bus.empty_i   = 1'b0;
    bus.awaddr_i  = 16'(addr);
    bus.awid_i    = 4'(id);
    bus.awlen_i   = 8'(len);
    bus.awsize_i  = 3'(size);
    bus.awburst_i = 2'(burst);
    #1;
    check_eq("idle_wready", 32'(bus.wready_o), 0);
    check_eq("idle_rden", 32'(bus.rden_o), 1);

    for (int i = 0; i <= len; i++) begin
      ng = 0;
      if (gap_mode == 1 && ($urandom % 4) == 0) ng = $urandom_range(1, 2);
      if (gap_mode == 2 && (i % 2) == 1) ng = 1;
      repeat (ng) begin
        @(negedge clk);
        bus.empty_i  = 1'b1;
        bus.wvalid_i = 1'b0;
        bus.wlast_i  = 1'b0;
        #1;
        check_eq("gap_wready", 32'(bus.wready_o), 1);
        check_eq("gap_memwr", 32'(bus.mem_wren_o), 0);
        check_eq("gap_wstrb", 32'(bus.mem_wstrb_o), 0);
      end
      @(negedge clk);
      strb = BYTES'($urandom);
      bus.empty_i  = 1'b1;
      bus.wvalid_i = 1'b1;
      bus.wid_i    = bad_wid ? 4'(id ^ 1) : 4'(id);
      bus.wstrb_i  = strb;
      bus.wlast_i  = (i == wlast_beat);
      #1;
      check_eq("beat_wready", 32'(bus.wready_o), 1);
      check_eq("beat_memwr", 32'(bus.mem_wren_o), 1);
      check_eq("beat_waddr", 32'(bus.mem_waddr_o), 32'(model_addr(addr, len, size, burst, i)));
      check_eq("beat_wstrb", 32'(bus.mem_wstrb_o), 32'(strb));
      check_eq("beat_wren", 32'(bus.wren_o), 0);
    end

    for (int k = 0; k < n_full; k++) begin
      @(negedge clk);
      bus.wvalid_i = 1'b1;
      bus.wlast_i  = 1'b0;
      bus.full_i   = 1'b1;
      #1;
      check_eq("full_wready", 32'(bus.wready_o), 0);
      check_eq("full_memwr", 32'(bus.mem_wren_o), 0);
      check_eq("full_wren", 32'(bus.wren_o), 0);
    end
    @(negedge clk);
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    bus.full_i   = 1'b0;
    #1;
    check_eq("resp_wready", 32'(bus.wready_o), 0);
    check_eq("resp_wren", 32'(bus.wren_o), 1);
    check_eq("resp_bid", 32'(bus.bid_o), 32'(id));
    check_eq("resp_bresp", 32'(bus.bresp_o), exp_err ? 32'd2 : 32'd0);
  endtask

  initial begin
    int len;
    int burst;
    int size;
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    bus.awaddr_i  = '0;
    bus.awid_i    = '0;
    bus.awlen_i   = '0;
    bus.awsize_i  = '0;
    bus.awburst_i = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(16'h0100, 5, 3, 4, 1, 3, 1'b0, 0, 0);
    run_burst(16'h0138, 2, 3, 3, 2, 3, 1'b0, 0, 0);
    run_burst(16'h0044, 7, 2, 4, 0, 2, 1'b0, 0, 0);
    run_burst(16'h0200, 1, 3, 4, 1, 1, 1'b0, 0, 0);
    run_burst(16'h0300, 3, 1, 4, 1, 1, 1'b1, 0, 0);
    run_burst(16'h0400, 4, 2, 4, 3, 2, 1'b0, 0, 0);
    run_burst(16'h0500, 6, 1, 4, 1, 1, 1'b0, 0, 5);
    run_burst(16'h0600, 8, 5, 2, 1, 5, 1'b0, 2, 0);
    run_burst(16'hfff0, 9, 3, 4, 1, 3, 1'b0, 0, 0);

    // Reset on beat 2 of an 8-beat burst drops it without a B push.
    @(negedge clk);
    bus.empty_i = 1'b0; bus.awaddr_i = 16'h0700; bus.awid_i = 4'h9;
    bus.awlen_i = 8'd7; bus.awsize_i = 3'd4; bus.awburst_i = 2'b01;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.empty_i = 1'b1; bus.wvalid_i = 1'b1; bus.wid_i = 4'h9;
      bus.wstrb_i = '1; bus.wlast_i = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("postrst_wren", 32'(bus.wren_o), 0);
      check_eq("postrst_wready", 32'(bus.wready_o), 0);
    end

    for (int n = 0; n < 60; n++) begin
      burst = $urandom_range(0, 3);
      size  = (($urandom % 6) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      if (burst == 2 && ($urandom % 5) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else if (($urandom % 20) == 0)         len = $urandom_range(100, 255);
      else                                   len = $urandom_range(0, 12);
      run_burst($urandom_range(0, 16'hffff), $urandom_range(0, 15), len, size, burst,
                (($urandom % 8) == 0) ? $urandom_range(0, len) : len,
                (($urandom % 8) == 0), $urandom_range(0, 1),
                (($urandom % 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
